// File: rtl/piarb_buf_writer_if.sv
// Bus bundle between the PI arbiter buffer writer, its upstream PU source and
// the buffer manager (free-buffer, shared-memory write and enqueue ports).
interface piarb_buf_writer_if #(
    parameter int unsigned BPTR_NBITS = 8,
    parameter int unsigned DATA_NBITS = 32,
    parameter int unsigned ID_NBITS   = 4,
    parameter int unsigned LEN_NBITS  = 4
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sop;
    logic                  in_eop;
    logic [DATA_NBITS-1:0] in_data;
    logic [ID_NBITS-1:0]   in_port_id;
    logic [ID_NBITS-1:0]   in_qid;

    logic                  free_buf_req;
    logic                  free_buf_valid;
    logic [BPTR_NBITS-1:0] free_buf_ptr;
    logic                  free_buf_available;

    logic                  write_data_valid;
    logic [BPTR_NBITS-1:0] write_buf_ptr;
    logic [DATA_NBITS-1:0] write_data;
    logic                  write_sop;
    logic [ID_NBITS-1:0]   write_port_id;

    logic                  enq_req;
    logic [ID_NBITS-1:0]   enq_qid;
    logic [BPTR_NBITS-1:0] enq_head_ptr;
    logic [LEN_NBITS-1:0]  enq_len;
    logic                  enq_ack;

    logic                  proto_err;

    // Writer side
    modport master (
        input  in_valid, in_sop, in_eop, in_data, in_port_id, in_qid,
        input  free_buf_valid, free_buf_ptr, free_buf_available,
        input  enq_ack,
        output in_ready, free_buf_req,
        output write_data_valid, write_buf_ptr, write_data, write_sop, write_port_id,
        output enq_req, enq_qid, enq_head_ptr, enq_len,
        output proto_err
    );

    // Environment side (PU source + buffer manager)
    modport slave (
        output in_valid, in_sop, in_eop, in_data, in_port_id, in_qid,
        output free_buf_valid, free_buf_ptr, free_buf_available,
        output enq_ack,
        input  in_ready, free_buf_req,
        input  write_data_valid, write_buf_ptr, write_data, write_sop, write_port_id,
        input  enq_req, enq_qid, enq_head_ptr, enq_len,
        input  proto_err
    );
endinterface

// File: rtl/piarb_buf_writer.sv
// Write-side front end of the PI arbiter buffer manager: prefetches free buffer
// pointers, writes packet chunks to shared memory and enqueues one descriptor per packet.
module piarb_buf_writer #(
    parameter int unsigned BPTR_NBITS = 8,
    parameter int unsigned DATA_NBITS = 32,
    parameter int unsigned ID_NBITS   = 4,
    parameter int unsigned LEN_NBITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    piarb_buf_writer_if.master   bus
);
    localparam int unsigned CNT_NBITS = 2;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam logic [LEN_NBITS-1:0] LEN_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_IN_PKT,
        S_ENQ
    } state_e;

    state_e                state_q, state_d;

    logic [BPTR_NBITS-1:0] ptr_mem_q [FIFO_DEPTH];
    logic [BPTR_NBITS-1:0] ptr_mem_d [FIFO_DEPTH];
    logic                  rd_idx_q, rd_idx_d;
    logic                  wr_idx_q, wr_idx_d;
    logic [CNT_NBITS-1:0]  cnt_q, cnt_d;
    logic                  outstanding_q, outstanding_d;
    logic                  free_buf_req_q, free_buf_req_d;

    logic [BPTR_NBITS-1:0] head_q, head_d;
    logic [ID_NBITS-1:0]   qid_q, qid_d;
    logic [ID_NBITS-1:0]   port_q, port_d;
    logic [LEN_NBITS-1:0]  len_q, len_d;
    logic                  enq_req_q, enq_req_d;

    logic                  wr_valid_q, wr_valid_d;
    logic [BPTR_NBITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DATA_NBITS-1:0] wr_data_q, wr_data_d;
    logic                  wr_sop_q, wr_sop_d;
    logic [ID_NBITS-1:0]   wr_port_q, wr_port_d;
    logic                  proto_err_q, proto_err_d;

    logic                  in_ready_c;
    logic                  accept_c;
    logic                  push_c;
    logic                  pop_c;

    // A non-sop beat in IDLE is dropped without a pointer, so it is accepted even with an empty FIFO
    assign in_ready_c = !rst && (((cnt_q != '0) && (state_q != S_ENQ)) ||
                                 ((state_q == S_IDLE) && bus.in_valid && !bus.in_sop));
    assign accept_c   = bus.in_valid && in_ready_c;

    // Next-state, FIFO and output computation
    always_comb begin
        state_d        = state_q;
        ptr_mem_d      = ptr_mem_q;
        rd_idx_d       = rd_idx_q;
        wr_idx_d       = wr_idx_q;
        cnt_d          = cnt_q;
        outstanding_d  = outstanding_q;
        free_buf_req_d = 1'b0;
        head_d         = head_q;
        qid_d          = qid_q;
        port_d         = port_q;
        len_d          = len_q;
        enq_req_d      = 1'b0;
        wr_valid_d     = 1'b0;
        wr_ptr_d       = wr_ptr_q;
        wr_data_d      = wr_data_q;
        wr_sop_d       = 1'b0;
        wr_port_d      = wr_port_q;
        proto_err_d    = 1'b0;
        push_c         = 1'b0;
        pop_c          = 1'b0;

        if (bus.free_buf_valid) begin
            if (outstanding_q) begin
                push_c = 1'b1;
            end else begin
                proto_err_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (bus.in_sop) begin
                        pop_c      = 1'b1;
                        head_d     = ptr_mem_q[rd_idx_q];
                        qid_d      = bus.in_qid;
                        port_d     = bus.in_port_id;
                        len_d      = LEN_NBITS'(1);
                        wr_valid_d = 1'b1;
                        wr_ptr_d   = ptr_mem_q[rd_idx_q];
                        wr_data_d  = bus.in_data;
                        wr_sop_d   = 1'b1;
                        wr_port_d  = bus.in_port_id;
                        state_d    = bus.in_eop ? S_ENQ : S_IN_PKT;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            S_IN_PKT: begin
                if (accept_c) begin
                    pop_c      = 1'b1;
                    wr_valid_d = 1'b1;
                    wr_ptr_d   = ptr_mem_q[rd_idx_q];
                    wr_data_d  = bus.in_data;
                    wr_port_d  = port_q;
                    if (bus.in_sop) begin
                        proto_err_d = 1'b1;
                    end
                    // Length saturates; the overflowing beat is still written
                    if (len_q == LEN_MAX) begin
                        proto_err_d = 1'b1;
                    end else begin
                        len_d = len_q + LEN_NBITS'(1);
                    end
                    if (bus.in_eop) begin
                        state_d = S_ENQ;
                    end
                end
            end
            S_ENQ: begin
                if (bus.enq_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push_c) begin
            ptr_mem_d[wr_idx_q] = bus.free_buf_ptr;
            wr_idx_d            = !wr_idx_q;
        end
        if (pop_c) begin
            rd_idx_d = !rd_idx_q;
        end
        cnt_d = cnt_q + CNT_NBITS'(push_c) - CNT_NBITS'(pop_c);

        // Only one pointer request in flight at a time
        free_buf_req_d = !outstanding_q && bus.free_buf_available &&
                         (cnt_q < CNT_NBITS'(FIFO_DEPTH));
        outstanding_d  = (outstanding_q && !bus.free_buf_valid) || free_buf_req_d;

        enq_req_d = (state_d == S_ENQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ptr_mem_q[i] <= '0;
            end
            rd_idx_q       <= 1'b0;
            wr_idx_q       <= 1'b0;
            cnt_q          <= '0;
            outstanding_q  <= 1'b0;
            free_buf_req_q <= 1'b0;
            head_q         <= '0;
            qid_q          <= '0;
            port_q         <= '0;
            len_q          <= '0;
            enq_req_q      <= 1'b0;
            wr_valid_q     <= 1'b0;
            wr_ptr_q       <= '0;
            wr_data_q      <= '0;
            wr_sop_q       <= 1'b0;
            wr_port_q      <= '0;
            proto_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_mem_q      <= ptr_mem_d;
            rd_idx_q       <= rd_idx_d;
            wr_idx_q       <= wr_idx_d;
            cnt_q          <= cnt_d;
            outstanding_q  <= outstanding_d;
            free_buf_req_q <= free_buf_req_d;
            head_q         <= head_d;
            qid_q          <= qid_d;
            port_q         <= port_d;
            len_q          <= len_d;
            enq_req_q      <= enq_req_d;
            wr_valid_q     <= wr_valid_d;
            wr_ptr_q       <= wr_ptr_d;
            wr_data_q      <= wr_data_d;
            wr_sop_q       <= wr_sop_d;
            wr_port_q      <= wr_port_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign bus.in_ready         = in_ready_c;
    assign bus.free_buf_req     = free_buf_req_q;
    assign bus.write_data_valid = wr_valid_q;
    assign bus.write_buf_ptr    = wr_ptr_q;
    assign bus.write_data       = wr_data_q;
    assign bus.write_sop        = wr_sop_q;
    assign bus.write_port_id    = wr_port_q;
    assign bus.enq_req          = enq_req_q;
    assign bus.enq_qid          = qid_q;
    assign bus.enq_head_ptr     = head_q;
    assign bus.enq_len          = len_q;
    assign bus.proto_err        = proto_err_q;

endmodule

// File: tb/tb_piarb_buf_writer.sv
// Scoreboard bench for piarb_buf_writer: directed packets push expected writes and
// descriptors; a negedge monitor pops and compares whatever the DUT presents.
module tb_piarb_buf_writer;
    localparam int unsigned BPTR_NBITS = 8;
    localparam int unsigned DATA_NBITS = 32;
    localparam int unsigned ID_NBITS   = 4;
    localparam int unsigned LEN_NBITS  = 4;

    typedef struct {
        logic [BPTR_NBITS-1:0] ptr;
        logic [DATA_NBITS-1:0] data;
        logic                  sop;
        logic [ID_NBITS-1:0]   port;
    } wr_t;

    typedef struct {
        logic [ID_NBITS-1:0]   qid;
        logic [BPTR_NBITS-1:0] head;
        logic [LEN_NBITS-1:0]  len;
    } enq_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    piarb_buf_writer_if #(
        .BPTR_NBITS(BPTR_NBITS), .DATA_NBITS(DATA_NBITS),
        .ID_NBITS(ID_NBITS), .LEN_NBITS(LEN_NBITS)
    ) bus ();

    piarb_buf_writer #(
        .BPTR_NBITS(BPTR_NBITS), .DATA_NBITS(DATA_NBITS),
        .ID_NBITS(ID_NBITS), .LEN_NBITS(LEN_NBITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    wr_t                   exp_wq[$];
    enq_t                  exp_eq[$];
    logic [BPTR_NBITS-1:0] model_q[$];

    int checks = 0;
    int errors = 0;
    int obs_err = 0;
    int enq_cycles = 0;
    int last_enq_cycles = 0;
    bit enq_active = 1'b0;
    enq_t cur_enq;

    int pend_cnt = 0;
    int stray_req = 0;
    int stray_done = 0;
    logic [BPTR_NBITS-1:0] next_ptr = 8'h10;

    bit ack_tied = 1'b0;
    int ack_delay = 0;
    int ack_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Buffer-manager model: returns sequential pointers two cycles after each request
    always @(negedge clk) begin
        bus.free_buf_valid = 1'b0;
        if (rst) begin
            pend_cnt = 0;
        end else begin
            if (stray_done != stray_req) begin
                bus.free_buf_valid = 1'b1;
                bus.free_buf_ptr   = 8'hEE;
                stray_done++;
            end else if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.free_buf_valid = 1'b1;
                    bus.free_buf_ptr   = next_ptr;
                    model_q.push_back(next_ptr);
                    next_ptr = next_ptr + 8'd1;
                end
            end
            if (bus.free_buf_req) pend_cnt = 2;
        end
    end

    // Descriptor consumer: ack tied high, or after ack_delay cycles of enq_req
    always @(negedge clk) begin
        if (rst || !bus.enq_req) begin
            ack_cyc     = 0;
            bus.enq_ack = ack_tied;
        end else begin
            ack_cyc++;
            bus.enq_ack = ack_tied || (ack_cyc > ack_delay);
        end
    end

    // Monitor: pops expected writes/descriptors when the DUT presents them
    always @(negedge clk) begin
        if (rst) begin
            enq_active = 1'b0;
        end else begin
            wr_t e;
            if (bus.proto_err) obs_err++;
            if (bus.write_data_valid) begin
                if (exp_wq.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    e = exp_wq.pop_front();
                    chk("write_buf_ptr", 64'(bus.write_buf_ptr), 64'(e.ptr));
                    chk("write_data", 64'(bus.write_data), 64'(e.data));
                    chk("write_sop", 64'(bus.write_sop), 64'(e.sop));
                    chk("write_port_id", 64'(bus.write_port_id), 64'(e.port));
                end
            end
            if (bus.enq_req) begin
                if (!enq_active) begin
                    enq_active = 1'b1;
                    enq_cycles = 1;
                    if (exp_eq.size() == 0) begin
                        fail_now("unexpected_enq");
                        cur_enq = '{qid: bus.enq_qid, head: bus.enq_head_ptr, len: bus.enq_len};
                    end else begin
                        cur_enq = exp_eq.pop_front();
                    end
                end else begin
                    enq_cycles++;
                end
                chk("enq_qid", 64'(bus.enq_qid), 64'(cur_enq.qid));
                chk("enq_head_ptr", 64'(bus.enq_head_ptr), 64'(cur_enq.head));
                chk("enq_len", 64'(bus.enq_len), 64'(cur_enq.len));
                chk("in_ready_during_enq", 64'(bus.in_ready), 64'd0);
            end else if (enq_active) begin
                enq_active      = 1'b0;
                last_enq_cycles = enq_cycles;
            end
        end
    end

    task automatic send(input bit sop, input bit eop, input logic [31:0] data,
                        input logic [3:0] port, input logic [3:0] qid,
                        input bit consume, input bit exp_sop, input int fixed_ptr,
                        output logic [7:0] ptr);
        int n = 0;
        logic [7:0] p;
        ptr = '0;
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_sop     = sop;
        bus.in_eop     = eop;
        bus.in_data    = data;
        bus.in_port_id = port;
        bus.in_qid     = qid;
        #1;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            fail_now("accept_timeout");
        end else if (consume) begin
            if (model_q.size() == 0) begin
                fail_now("accept_without_pointer");
            end else begin
                p = model_q.pop_front();
                if (fixed_ptr >= 0) p = 8'(fixed_ptr);
                ptr = p;
                exp_wq.push_back('{ptr: p, data: data, sop: exp_sop, port: port});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
    endtask

    task automatic expect_enq(input logic [3:0] qid, input logic [7:0] head, input logic [3:0] len);
        exp_eq.push_back('{qid: qid, head: head, len: len});
    endtask

    task automatic wait_full();
        int k = 0;
        while ((model_q.size() < 2 || pend_cnt != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) fail_now("prefetch_timeout");
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_free_buf_req"}, 64'(bus.free_buf_req), 64'd0);
        chk({tag, "_write_data_valid"}, 64'(bus.write_data_valid), 64'd0);
        chk({tag, "_write_sop"}, 64'(bus.write_sop), 64'd0);
        chk({tag, "_enq_req"}, 64'(bus.enq_req), 64'd0);
        chk({tag, "_proto_err"}, 64'(bus.proto_err), 64'd0);
        chk({tag, "_write_buf_ptr"}, 64'(bus.write_buf_ptr), 64'd0);
        chk({tag, "_write_data"}, 64'(bus.write_data), 64'd0);
        chk({tag, "_write_port_id"}, 64'(bus.write_port_id), 64'd0);
        chk({tag, "_enq_qid"}, 64'(bus.enq_qid), 64'd0);
        chk({tag, "_enq_head_ptr"}, 64'(bus.enq_head_ptr), 64'd0);
        chk({tag, "_enq_len"}, 64'(bus.enq_len), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p, head;
        int err_base;

        bus.in_valid           = 1'b0;
        bus.in_sop             = 1'b0;
        bus.in_eop             = 1'b0;
        bus.in_data            = '0;
        bus.in_port_id         = '0;
        bus.in_qid             = '0;
        bus.free_buf_available = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("first_free_buf_req", 64'(bus.free_buf_req), 64'd1);

        // 3-chunk packet, qid=5 port=2 -> writes 0x10,0x11,0x12; descriptor head 0x10 len 3
        wait_full();
        err_base = obs_err;
        send(1'b1, 1'b0, 32'hA000_0001, 4'd2, 4'd5, 1'b1, 1'b1, 32'h10, head);
        send(1'b0, 1'b0, 32'hA000_0002, 4'd2, 4'd5, 1'b1, 1'b0, 32'h11, p);
        send(1'b0, 1'b1, 32'hA000_0003, 4'd2, 4'd5, 1'b1, 1'b0, 32'h12, p);
        expect_enq(4'd5, 8'h10, 4'd3);
        idle_in();
        repeat (6) @(negedge clk);
        chk("pkt3_proto_err_count", 64'(obs_err - err_base), 64'd0);

        // Single sop+eop chunk, enq_ack tied high
        wait_full();
        ack_tied = 1'b1;
        send(1'b1, 1'b1, 32'hB000_0001, 4'd3, 4'd7, 1'b1, 1'b1, -1, head);
        expect_enq(4'd7, head, 4'd1);
        idle_in();
        @(negedge clk);
        #1;
        chk("single_in_ready_after_ack", 64'(bus.in_ready), 64'd1);
        chk("single_enq_req_dropped", 64'(bus.enq_req), 64'd0);
        chk("single_enq_cycles", 64'(last_enq_cycles), 64'd1);
        ack_tied = 1'b0;

        // Availability withdrawn: no requests, 2-chunk packet stalls after chunk 1
        wait_full();
        bus.free_buf_available = 1'b0;
        send(1'b1, 1'b1, 32'hC000_0001, 4'd1, 4'd4, 1'b1, 1'b1, -1, head);
        expect_enq(4'd4, head, 4'd1);
        idle_in();
        repeat (3) @(negedge clk);
        send(1'b1, 1'b0, 32'hC000_0002, 4'd1, 4'd6, 1'b1, 1'b1, -1, head);
        @(negedge clk);
        bus.in_sop  = 1'b0;
        bus.in_eop  = 1'b1;
        bus.in_data = 32'hC000_0003;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_free_buf_req", 64'(bus.free_buf_req), 64'd0);
            @(negedge clk);
        end
        bus.free_buf_available = 1'b1;
        send(1'b0, 1'b1, 32'hC000_0003, 4'd1, 4'd6, 1'b1, 1'b0, -1, p);
        expect_enq(4'd6, head, 4'd2);
        idle_in();

        // Non-sop beat in IDLE is dropped; stray pointer return is flagged
        wait_full();
        err_base = obs_err;
        send(1'b0, 1'b0, 32'hD000_0001, 4'd2, 4'd2, 1'b0, 1'b0, -1, p);
        idle_in();
        repeat (4) @(negedge clk);
        chk("idle_nonsop_proto_err", 64'(obs_err - err_base), 64'd1);
        stray_req++;
        repeat (5) @(negedge clk);
        chk("stray_valid_proto_err", 64'(obs_err - err_base), 64'd2);

        // sop in the middle of a packet continues it
        err_base = obs_err;
        send(1'b1, 1'b0, 32'hD100_0001, 4'd9, 4'd3, 1'b1, 1'b1, -1, head);
        send(1'b1, 1'b0, 32'hD100_0002, 4'd9, 4'd3, 1'b1, 1'b0, -1, p);
        send(1'b0, 1'b1, 32'hD100_0003, 4'd9, 4'd3, 1'b1, 1'b0, -1, p);
        expect_enq(4'd3, head, 4'd3);
        idle_in();
        repeat (6) @(negedge clk);
        chk("mid_sop_proto_err", 64'(obs_err - err_base), 64'd1);

        // enq_ack held off: descriptor stable for 6 cycles
        wait_full();
        ack_delay = 5;
        send(1'b1, 1'b1, 32'hE000_0001, 4'd4, 4'd8, 1'b1, 1'b1, -1, head);
        expect_enq(4'd8, head, 4'd1);
        idle_in();
        repeat (10) @(negedge clk);
        chk("held_enq_cycles", 64'(last_enq_cycles), 64'd6);
        ack_delay = 0;

        // 16 chunks: length saturates at 15, error on chunk 16
        wait_full();
        err_base = obs_err;
        for (int i = 0; i < 16; i++) begin
            send(i == 0, i == 15, 32'hF000_0000 + 32'(i), 4'd6, 4'd10, 1'b1, i == 0, -1, p);
            if (i == 0) head = p;
        end
        expect_enq(4'd10, head, 4'd15);
        idle_in();
        repeat (6) @(negedge clk);
        chk("saturate_proto_err", 64'(obs_err - err_base), 64'd1);

        // Reset during IN_PKT after two chunks
        wait_full();
        send(1'b1, 1'b0, 32'h1234_0001, 4'd5, 4'd11, 1'b1, 1'b1, -1, p);
        send(1'b0, 1'b0, 32'h1234_0002, 4'd5, 4'd11, 1'b1, 1'b0, -1, p);
        idle_in();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_q.delete();
        @(negedge clk);
        chk_reset_outputs("midpkt_reset");
        rst = 1'b0;
        wait_full();
        send(1'b1, 1'b0, 32'h5678_0001, 4'd7, 4'd12, 1'b1, 1'b1, -1, head);
        send(1'b0, 1'b1, 32'h5678_0002, 4'd7, 4'd12, 1'b1, 1'b0, -1, p);
        expect_enq(4'd12, head, 4'd2);
        idle_in();
        repeat (10) @(negedge clk);

        chk("pending_writes_left", 64'(exp_wq.size()), 64'd0);
        chk("pending_enqs_left", 64'(exp_eq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
